// File: rtl/mem_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stall_ctrl
// Description : Multi-port memory stall controller. Each port tracks one
//               outstanding request through IDLE / WAIT / DRAIN. The block
//               drives the global pipeline stall, returns per-port
//               request-ready and response-accept signals, drops wrong-path
//               responses after a flush, and flags timeouts and spurious
//               responses. A saturating counter records stalled cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk             in   1          clock, all state on rising edge
//   rst             in   1          synchronous active-high reset
//   req_i           in   NUM_PORTS  per-port request issued this cycle
//   resp_i          in   NUM_PORTS  per-port response returned this cycle
//   flush_i         in   1          pipeline flush, squashes in-flight requests
//   req_ready_o     out  NUM_PORTS  port may issue a request this cycle
//   resp_accept_o   out  NUM_PORTS  response valid, pipeline must consume it
//   busy_o          out  NUM_PORTS  port is in WAIT or DRAIN
//   stall_o         out  1          freeze pipeline stage registers
//   timeout_err_o   out  NUM_PORTS  sticky per-port timeout flag
//   spurious_err_o  out  NUM_PORTS  sticky flag: response seen while IDLE
//   stall_cycles_o  out  CNT_W      saturating count of stalled cycles
// ============================================================================
module mem_stall_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] resp_i,
    input  logic                 flush_i,
    output logic [NUM_PORTS-1:0] req_ready_o,
    output logic [NUM_PORTS-1:0] resp_accept_o,
    output logic [NUM_PORTS-1:0] busy_o,
    output logic                 stall_o,
    output logic [NUM_PORTS-1:0] timeout_err_o,
    output logic [NUM_PORTS-1:0] spurious_err_o,
    output logic [CNT_W-1:0]     stall_cycles_o
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_wait  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    localparam logic [TO_W-1:0] c_to_lim = TO_W'(TIMEOUT_CYC);
    localparam bit              c_to_en  = (TIMEOUT_CYC != 0);

    logic [NUM_PORTS-1:0] w_stall_port;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     stall_cnt_d;

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_port
            logic [1:0]      state_q;
            logic [1:0]      state_d;
            logic [TO_W-1:0] to_cnt_q;
            logic [TO_W-1:0] to_cnt_d;
            logic [TO_W-1:0] w_to_inc;
            logic            to_err_q;
            logic            to_err_d;
            logic            spur_q;
            logic            spur_d;
            logic            w_cnt_clr;
            logic            w_ready;
            logic            w_accept;
            logic            w_stall;

            assign w_to_inc = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

            always_comb begin
                state_d   = state_q;
                spur_d    = spur_q;
                w_cnt_clr = 1'b0;
                w_ready   = 1'b0;
                w_accept  = 1'b0;
                w_stall   = 1'b0;
                case (state_q)
                    c_idle: begin
                        w_ready = !flush_i;
                        if (resp_i[g]) begin
                            spur_d = 1'b1;
                        end
                        if (req_i[g] && !flush_i) begin
                            state_d   = c_wait;
                            w_cnt_clr = 1'b1;
                        end
                    end
                    c_wait: begin
                        if (resp_i[g]) begin
                            w_cnt_clr = 1'b1;
                            if (!flush_i) begin
                                w_accept = 1'b1;
                                w_ready  = 1'b1;
                                // A request in the response cycle chains
                                // straight into a fresh wait.
                                state_d  = req_i[g] ? c_wait : c_idle;
                            end else begin
                                // Flushed response: data and any same-cycle
                                // request are both wrong-path.
                                state_d = c_idle;
                            end
                        end else begin
                            w_stall = 1'b1;
                            if (flush_i) begin
                                state_d = c_drain;
                            end
                        end
                    end
                    c_drain: begin
                        // Hold the pipeline until the squashed response has
                        // been swallowed, so it cannot be mistaken for the
                        // reply to a post-flush request.
                        w_stall = 1'b1;
                        if (resp_i[g]) begin
                            state_d   = c_idle;
                            w_cnt_clr = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = c_idle;
                        w_cnt_clr = 1'b1;
                    end
                endcase
            end

            always_comb begin
                to_cnt_d = to_cnt_q;
                to_err_d = to_err_q;
                if (w_cnt_clr) begin
                    to_cnt_d = '0;
                end else if (state_q != c_idle) begin
                    to_cnt_d = w_to_inc;
                    if (c_to_en && (w_to_inc == c_to_lim)) begin
                        to_err_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= c_idle;
                    to_cnt_q <= '0;
                    to_err_q <= 1'b0;
                    spur_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    to_cnt_q <= to_cnt_d;
                    to_err_q <= to_err_d;
                    spur_q   <= spur_d;
                end
            end

            assign req_ready_o[g]    = w_ready;
            assign resp_accept_o[g]  = w_accept;
            assign busy_o[g]         = (state_q != c_idle);
            assign timeout_err_o[g]  = to_err_q;
            assign spurious_err_o[g] = spur_q;
            assign w_stall_port[g]   = w_stall;
        end
    endgenerate

    assign stall_o = |w_stall_port;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;

endmodule
`default_nettype wire
